stream_merge_rr: RTL and testbench
==================================

Name: stream_merge_rr

Overview:
- Packet-granular round-robin merger of four AXI-stream channels into one stream; the inverse of the channel split used in front of the per-channel predistorters.
- Sits between per-channel processing cores and a single axi_wrapper s_axis_data input.
- Tags each output beat with its source channel.
- Enforces a maximum packet length so a runaway channel cannot lock the output.

Parameters:
- WIDTH, 16: tdata width of each input and of the output.
- ACTIVE_MASK, 4'b1111: bit n set means input n takes part in arbitration. Inactive inputs are sunk and their data discarded.
- MAX_PKT_LEN, 4096: maximum beats per output packet, from 1 to 65535. The beat counter is 16 bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear; same effect as reset, one cycle
- i0_tdata / i1_tdata / i2_tdata / i3_tdata  in  WIDTH  per-channel data
- i0..i3_tlast  in  1  end of packet
- i0..i3_tvalid  in  1  valid
- i0..i3_tready  out  1  ready
- o_tdata  out  WIDTH  merged data
- o_tuser  out  2  source channel index of the current beat
- o_tlast  out  1  end of output packet
- o_tvalid  out  1  valid
- o_tready  in  1  ready
- err_stb  out  1  one-cycle pulse when a packet is truncated
- err_chan  out  2  channel of the last truncation; held until the next error

Behaviour:
- Reset and clear values: o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0, err_stb=0, err_chan=0, state=IDLE, last_grant=3 (so channel 0 wins first), beat count=0.
- Ready on inactive channels: i*_tready of inactive channels is 1 at all times, including during reset.
- Ready on active channels: i*_tready of active channels is 0 during reset.
- Output register: single stage. It loads when a granted beat is accepted, provided o_tvalid=0 or o_tready=1. o_tvalid stays high until o_tready is seen. o_tdata/o_tuser/o_tlast are stable while o_tvalid=1 and o_tready=0.
- FSM states: IDLE, PASS, DROP.
- IDLE:
  - Scan channels (last_grant+1) mod 4, +2, +3, +4 in that order and pick the first that is active with tvalid=1.
  - Register grant=that channel, beat count=0, then go to PASS.
  - All i*_tready of active channels are 0.
  - With no candidate, stay in IDLE.
- PASS:
  - Only i[grant]_tready = (~o_tvalid | o_tready). All other active channels have tready 0.
  - On each accepted beat, count increments.
  - If the accepted beat has tlast=1: set last_grant=grant and go to IDLE.
  - Else if the new count equals MAX_PKT_LEN: output the beat with o_tlast forced to 1, pulse err_stb in the cycle after acceptance, set err_chan=grant, and go to DROP.
  - If tlast=1 and count=MAX_PKT_LEN occur on the same beat, it is a normal end with no error.
- DROP:
  - i[grant]_tready=1 and beats are discarded; the output register is not loaded.
  - On accepting tlast, set last_grant=grant and go to IDLE.
- Throughput: one beat per cycle inside a packet; exactly one idle cycle between packets for arbitration.
- Latency: first beat appears on the output 2 cycles after the tvalid it answers, when starting from IDLE.
- Fairness: with all four channels continuously valid, grants go 0,1,2,3,0,... one packet each.
- Stalled output: o_tready=0 with o_tvalid=1 holds the granted input's tready at 0. No data is lost or duplicated.
- Reset or clear mid-packet: the output packet is abandoned without tlast and any partial input packet is left upstream. Downstream and upstream are cleared together by the owning block.
- MAX_PKT_LEN=1: every packet is one beat. A multi-beat input yields one output beat with tlast, plus an error.

Test Plan:
- Reset, then ch0 sends a 4-beat packet 0x0001..0x0004 → output matches with o_tuser=0, o_tlast on beat 4, first o_tvalid 2 cycles after i0_tvalid.
- All four channels hold valid 3-beat packets with data 0xN000+k → output packet order ch0,ch1,ch2,ch3,ch0, one idle cycle between packets, o_tuser matches.
- ch2 sends 10 beats with no tlast until beat 10, MAX_PKT_LEN=4 → output has 4 beats with o_tlast on beat 4, err_stb one pulse, err_chan=2, beats 5..10 sunk, next grant goes to ch3.
- o_tready toggles 1,0,0,1 during a 6-beat ch1 packet → all 6 beats delivered once, in order, with outputs stable while stalled.
- ACTIVE_MASK=4'b0101 with ch1 and ch3 valid → i1_tready=i3_tready=1 constantly, no ch1/ch3 data on the output, ch0/ch2 arbitrated normally.
- reset asserted in the middle of a packet → outputs return to reset values asynchronously; after release, arbitration restarts at ch0.

Source files
------------

// File: rtl/stream_merge_rr_if.sv
// One AXI-stream link: data, source-channel tag, end-of-packet and the
// valid/ready handshake. The merger's inputs leave tuser unused.
interface stream_merge_rr_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic [1:0]       tuser;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/stream_merge_rr.sv
// Packet-granular round-robin merge of four AXI-stream channels into one.
// Each output beat is tagged with its source channel on tuser. Packets longer
// than MAX_PKT_LEN are cut short: the last forwarded beat carries a forced
// tlast, an error strobe fires and the rest of the input packet is sunk.
module stream_merge_rr #(
    parameter int         WIDTH       = 16,
    parameter logic [3:0] ACTIVE_MASK = 4'b1111,
    parameter int         MAX_PKT_LEN = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    stream_merge_rr_if.slave  i0,
    stream_merge_rr_if.slave  i1,
    stream_merge_rr_if.slave  i2,
    stream_merge_rr_if.slave  i3,
    stream_merge_rr_if.master o,
    output logic              err_stb,
    output logic [1:0]        err_chan
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [1:0]       lastGrant_q;
    logic [15:0]      beatCnt_q;
    logic [WIDTH-1:0] oData_q;
    logic [1:0]       oUser_q;
    logic             oLast_q;
    logic             oValid_q;
    logic             errStb_q;
    logic [1:0]       errChan_q;

    logic [WIDTH-1:0] inData [4];
    logic [3:0]       inLast;
    logic [3:0]       inValid;
    logic [3:0]       inReady;

    logic             pickValid_d;
    logic [1:0]       pick_d;
    logic [1:0]       scanIdx;
    logic             outSpace;
    logic             accept;
    logic [15:0]      beatCnt_d;
    logic             hitMax;

    assign inData[0] = i0.tdata;
    assign inData[1] = i1.tdata;
    assign inData[2] = i2.tdata;
    assign inData[3] = i3.tdata;
    assign inLast    = {i3.tlast, i2.tlast, i1.tlast, i0.tlast};
    assign inValid   = {i3.tvalid, i2.tvalid, i1.tvalid, i0.tvalid};

    assign i0.tready = inReady[0];
    assign i1.tready = inReady[1];
    assign i2.tready = inReady[2];
    assign i3.tready = inReady[3];

    assign o.tdata   = oData_q;
    assign o.tuser   = oUser_q;
    assign o.tlast   = oLast_q;
    assign o.tvalid  = oValid_q;
    assign err_stb   = errStb_q;
    assign err_chan  = errChan_q;

    // The output register can take a beat when it is empty or draining now.
    assign outSpace  = ~oValid_q | o.tready;
    assign accept    = inValid[grant_q] & inReady[grant_q];
    assign beatCnt_d = beatCnt_q + 16'd1;
    assign hitMax    = (beatCnt_d == MAX_LEN);

    // Round-robin scan starting just after the last granted channel.
    always_comb begin
        pickValid_d = 1'b0;
        pick_d      = 2'd0;
        scanIdx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scanIdx = lastGrant_q + 2'(k);
            if (!pickValid_d && ACTIVE_MASK[scanIdx] && inValid[scanIdx]) begin
                pickValid_d = 1'b1;
                pick_d      = scanIdx;
            end
        end
    end

    // Inactive channels always sink; only the granted active channel is ever ready.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            inReady[c] = ~ACTIVE_MASK[c];
        end
        if (!reset && !clear) begin
            case (state_q)
                PASS:    inReady[grant_q] = outSpace;
                DROP:    inReady[grant_q] = 1'b1;
                default: ;
            endcase
        end
    end

    // Arbitration FSM plus the single-stage output and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'd0;
            lastGrant_q <= 2'd3;
            beatCnt_q   <= 16'd0;
            oData_q     <= '0;
            oUser_q     <= 2'd0;
            oLast_q     <= 1'b0;
            oValid_q    <= 1'b0;
            errStb_q    <= 1'b0;
            errChan_q   <= 2'd0;
        end else if (clear) begin
            state_q     <= IDLE;
            grant_q     <= 2'd0;
            lastGrant_q <= 2'd3;
            beatCnt_q   <= 16'd0;
            oData_q     <= '0;
            oUser_q     <= 2'd0;
            oLast_q     <= 1'b0;
            oValid_q    <= 1'b0;
            errStb_q    <= 1'b0;
            errChan_q   <= 2'd0;
        end else begin
            errStb_q <= 1'b0;
            if (oValid_q && o.tready) begin
                oValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        grant_q   <= pick_d;
                        beatCnt_q <= 16'd0;
                        state_q   <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        beatCnt_q <= beatCnt_d;
                        oValid_q  <= 1'b1;
                        oData_q   <= inData[grant_q];
                        oUser_q   <= grant_q;
                        if (inLast[grant_q]) begin
                            oLast_q     <= 1'b1;
                            lastGrant_q <= grant_q;
                            state_q     <= IDLE;
                        end else if (hitMax) begin
                            oLast_q   <= 1'b1;
                            errStb_q  <= 1'b1;
                            errChan_q <= grant_q;
                            state_q   <= DROP;
                        end else begin
                            oLast_q <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (accept && inLast[grant_q]) begin
                        lastGrant_q <= grant_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_merge_rr.sv
// Bench for stream_merge_rr: three instances (default, MAX_PKT_LEN=4,
// ACTIVE_MASK=4'b0101) driven from per-channel packet queues and checked
// against a packet-level round-robin reference model.
module tb_stream_merge_rr;
    localparam int W = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  user;
        logic        last;
    } outBeat_t;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] inData  [3][4];
    logic        inLast  [3][4];
    logic        inValid [3][4];
    wire         inReady [3][4];
    logic        outReady [3];
    wire  [15:0] outData  [3];
    wire  [1:0]  outUser  [3];
    wire         outLast  [3];
    wire         outValid [3];
    wire         errStb   [3];
    wire  [1:0]  errChan  [3];

    stream_merge_rr_if #(.WIDTH(W)) inA [4] ();
    stream_merge_rr_if #(.WIDTH(W)) inB [4] ();
    stream_merge_rr_if #(.WIDTH(W)) inC [4] ();
    stream_merge_rr_if #(.WIDTH(W)) outA ();
    stream_merge_rr_if #(.WIDTH(W)) outB ();
    stream_merge_rr_if #(.WIDTH(W)) outC ();

    for (genvar c = 0; c < 4; c++) begin : gConn
        assign inA[c].tdata  = inData[0][c];
        assign inA[c].tlast  = inLast[0][c];
        assign inA[c].tvalid = inValid[0][c];
        assign inA[c].tuser  = 2'd0;
        assign inReady[0][c] = inA[c].tready;
        assign inB[c].tdata  = inData[1][c];
        assign inB[c].tlast  = inLast[1][c];
        assign inB[c].tvalid = inValid[1][c];
        assign inB[c].tuser  = 2'd0;
        assign inReady[1][c] = inB[c].tready;
        assign inC[c].tdata  = inData[2][c];
        assign inC[c].tlast  = inLast[2][c];
        assign inC[c].tvalid = inValid[2][c];
        assign inC[c].tuser  = 2'd0;
        assign inReady[2][c] = inC[c].tready;
    end

    assign outA.tready = outReady[0];
    assign outB.tready = outReady[1];
    assign outC.tready = outReady[2];
    assign outData[0] = outA.tdata;  assign outUser[0] = outA.tuser;
    assign outLast[0] = outA.tlast;  assign outValid[0] = outA.tvalid;
    assign outData[1] = outB.tdata;  assign outUser[1] = outB.tuser;
    assign outLast[1] = outB.tlast;  assign outValid[1] = outB.tvalid;
    assign outData[2] = outC.tdata;  assign outUser[2] = outC.tuser;
    assign outLast[2] = outC.tlast;  assign outValid[2] = outC.tvalid;

    stream_merge_rr #(.WIDTH(W), .ACTIVE_MASK(4'b1111), .MAX_PKT_LEN(4096)) dutA (
        .clk(clk), .reset(reset), .clear(clear),
        .i0(inA[0]), .i1(inA[1]), .i2(inA[2]), .i3(inA[3]), .o(outA),
        .err_stb(errStb[0]), .err_chan(errChan[0]));

    stream_merge_rr #(.WIDTH(W), .ACTIVE_MASK(4'b1111), .MAX_PKT_LEN(4)) dutB (
        .clk(clk), .reset(reset), .clear(clear),
        .i0(inB[0]), .i1(inB[1]), .i2(inB[2]), .i3(inB[3]), .o(outB),
        .err_stb(errStb[1]), .err_chan(errChan[1]));

    stream_merge_rr #(.WIDTH(W), .ACTIVE_MASK(4'b0101), .MAX_PKT_LEN(4096)) dutC (
        .clk(clk), .reset(reset), .clear(clear),
        .i0(inC[0]), .i1(inC[1]), .i2(inC[2]), .i3(inC[3]), .o(outC),
        .err_stb(errStb[2]), .err_chan(errChan[2]));

    int         checkCount = 0;
    int         errorCount = 0;
    int         cur = 0;
    int         cyc = 0;
    int         startCyc = 0;
    int         readyMode = 0;
    int         readyIdx = 0;
    beat_t      srcQ [4][$];
    outBeat_t   expQ [$];
    outBeat_t   obsQ [$];
    int         obsCyc [$];
    int         expErrCount;
    logic [1:0] expErrChan;
    int         errPulses;
    int         errHighCycles;
    logic       prevErrStb;
    logic       stallPrev;
    logic [19:0] stallSnap;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait is never satisfied.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [3:0] maskOf(input int d);
        return (d == 2) ? 4'b0101 : 4'b1111;
    endfunction

    function automatic int maxOf(input int d);
        return (d == 1) ? 4 : 4096;
    endfunction

    function automatic bit allEmpty();
        for (int c = 0; c < 4; c++) begin
            if (srcQ[c].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic addPacket(input int c, input int len, input logic [15:0] base, input bit randData);
        beat_t b;
        for (int k = 1; k <= len; k++) begin
            b.data = randData ? 16'($urandom) : base + 16'(k);
            b.last = (k == len);
            srcQ[c].push_back(b);
        end
    endtask

    // Packet-level model: with every queued packet offered from the start,
    // grants rotate among active non-empty channels starting after channel 3.
    task automatic buildExpected(input int d);
        beat_t      q [4][$];
        beat_t      b;
        int         lg;
        int         g;
        int         n;
        int         mx;
        logic [3:0] m;
        m  = maskOf(d);
        mx = maxOf(d);
        for (int c = 0; c < 4; c++) q[c] = srcQ[c];
        expQ.delete();
        expErrCount = 0;
        expErrChan  = 2'd0;
        lg = 3;
        forever begin
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && m[(lg + k) % 4] && q[(lg + k) % 4].size() > 0) g = (lg + k) % 4;
            end
            if (g < 0) break;
            n = 0;
            do begin
                b = q[g].pop_front();
                n++;
                if (n < mx) begin
                    expQ.push_back('{b.data, 2'(g), b.last});
                end else if (n == mx) begin
                    expQ.push_back('{b.data, 2'(g), 1'b1});
                    if (!b.last) begin
                        expErrCount++;
                        expErrChan = 2'(g);
                    end
                end
            end while (!b.last);
            lg = g;
        end
    endtask

    task automatic applyStimulus();
        for (int c = 0; c < 4; c++) begin
            if (srcQ[c].size() > 0) begin
                inValid[cur][c] = 1'b1;
                inData[cur][c]  = srcQ[c][0].data;
                inLast[cur][c]  = srcQ[c][0].last;
            end else begin
                inValid[cur][c] = 1'b0;
                inData[cur][c]  = 16'd0;
                inLast[cur][c]  = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes and outputs at the falling edge, then
    // advance sources and output-ready 1 time unit after the rising edge.
    task automatic stepCycle();
        logic [3:0]  fire;
        logic [19:0] snap;
        @(negedge clk);
        for (int c = 0; c < 4; c++) fire[c] = inValid[cur][c] && inReady[cur][c];
        snap = {outValid[cur], outUser[cur], outLast[cur], outData[cur]};
        if (stallPrev) checkOutput("stallHold", {12'd0, snap}, {12'd0, stallSnap});
        if (outValid[cur] && outReady[cur]) begin
            obsQ.push_back('{outData[cur], outUser[cur], outLast[cur]});
            obsCyc.push_back(cyc);
        end
        stallPrev = outValid[cur] && !outReady[cur];
        stallSnap = snap;
        if (errStb[cur]) begin
            errHighCycles++;
            if (!prevErrStb) errPulses++;
        end
        prevErrStb = errStb[cur];
        if (cur == 2) begin
            checkOutput("maskReady1", 32'(inReady[2][1]), 1);
            checkOutput("maskReady3", 32'(inReady[2][3]), 1);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (fire[c]) void'(srcQ[c].pop_front());
        end
        applyStimulus();
        case (readyMode)
            1:       outReady[cur] = ($urandom_range(0, 3) != 0);
            2:       outReady[cur] = (readyIdx % 4 == 0) || (readyIdx % 4 == 3);
            default: outReady[cur] = 1'b1;
        endcase
        readyIdx++;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clear = 1'b0;
        for (int c = 0; c < 4; c++) srcQ[c].delete();
        for (int d = 0; d < 3; d++) begin
            outReady[d] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                inValid[d][c] = 1'b0;
                inData[d][c]  = 16'd0;
                inLast[d][c]  = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Run the queued traffic on DUT d to completion and compare with the model.
    task automatic runTest(input string name, input int d, input int mode);
        int n;
        int lim;
        cur = d;
        readyMode = mode;
        readyIdx = 0;
        obsQ.delete();
        obsCyc.delete();
        errPulses = 0;
        errHighCycles = 0;
        prevErrStb = 1'b0;
        stallPrev = 1'b0;
        buildExpected(d);
        outReady[d] = 1'b1;
        applyStimulus();
        startCyc = cyc;
        n = 0;
        while (!(allEmpty() && obsQ.size() == expQ.size() && !outValid[cur]) && n < 3000) begin
            stepCycle();
            n++;
        end
        checkOutput({name, "_timeout"}, 32'(n < 3000), 1);
        repeat (3) stepCycle();
        checkOutput({name, "_beatCount"}, 32'(obsQ.size()), 32'(expQ.size()));
        lim = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < lim; i++) begin
            checkOutput($sformatf("%s_beat%0d", name, i), {13'd0, obsQ[i]}, {13'd0, expQ[i]});
        end
        checkOutput({name, "_errPulses"}, 32'(errPulses), 32'(expErrCount));
        checkOutput({name, "_errHigh"}, 32'(errHighCycles), 32'(expErrCount));
        checkOutput({name, "_errChan"}, 32'(errChan[d]), 32'(expErrChan));
    endtask

    task automatic checkGaps(input string name);
        for (int i = 1; i < obsQ.size(); i++) begin
            if (obsQ[i-1].last) checkOutput($sformatf("%s_pktGap%0d", name, i), 32'(obsCyc[i] - obsCyc[i-1]), 2);
            else                checkOutput($sformatf("%s_beatGap%0d", name, i), 32'(obsCyc[i] - obsCyc[i-1]), 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(outValid[0]), 0);
        checkOutput("rstData", 32'(outData[0]), 0);
        checkOutput("rstUser", 32'(outUser[0]), 0);
        checkOutput("rstLast", 32'(outLast[0]), 0);
        checkOutput("rstErrStb", 32'(errStb[0]), 0);
        checkOutput("rstErrChan", 32'(errChan[0]), 0);
        checkOutput("rstReadyActive", 32'(inReady[0][0]), 0);
        checkOutput("rstReadyActiveC", 32'(inReady[2][2]), 0);
        checkOutput("rstReadyInactive1", 32'(inReady[2][1]), 1);
        checkOutput("rstReadyInactive3", 32'(inReady[2][3]), 1);
        reset = 1'b0;

        // Single 4-beat packet on channel 0: content, tag and latency.
        doReset();
        addPacket(0, 4, 16'h0000, 1'b0);
        runTest("single", 0, 0);
        checkOutput("latency", 32'((obsCyc.size() > 0) ? obsCyc[0] - startCyc : -1), 2);

        // All four channels busy: strict rotation, one idle cycle between packets.
        doReset();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) addPacket(c, 3, 16'(c << 12), 1'b0);
        end
        runTest("fair", 0, 0);
        checkGaps("fair");

        // Runaway channel 2 truncated at 4 beats; channel 3 follows.
        doReset();
        addPacket(2, 10, 16'h2000, 1'b0);
        addPacket(3, 3, 16'h3000, 1'b0);
        runTest("trunc", 1, 0);

        // Output stalls during a 6-beat channel 1 packet.
        doReset();
        addPacket(1, 6, 16'h1000, 1'b0);
        runTest("stall", 0, 2);

        // Inactive channels 1 and 3 are sunk, 0 and 2 rotate.
        doReset();
        for (int c = 0; c < 4; c++) begin
            addPacket(c, $urandom_range(1, 5), 16'd0, 1'b1);
            addPacket(c, $urandom_range(1, 5), 16'd0, 1'b1);
        end
        runTest("mask", 2, 1);

        // Asynchronous reset in the middle of a channel 1 packet.
        doReset();
        cur = 0;
        readyMode = 0;
        addPacket(1, 20, 16'd0, 1'b1);
        applyStimulus();
        repeat (6) stepCycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(outValid[0]), 0);
        checkOutput("midRstData", 32'(outData[0]), 0);
        checkOutput("midRstLast", 32'(outLast[0]), 0);
        checkOutput("midRstUser", 32'(outUser[0]), 0);
        checkOutput("midRstReady1", 32'(inReady[0][1]), 0);
        for (int c = 0; c < 4; c++) srcQ[c].delete();
        applyStimulus();
        @(posedge clk);
        #1;
        reset = 1'b0;
        addPacket(1, 2, 16'h1100, 1'b0);
        addPacket(0, 2, 16'h0100, 1'b0);
        runTest("afterRst", 0, 0);

        // Synchronous clear mid-packet must also restart arbitration at channel 0.
        doReset();
        addPacket(1, 1, 16'h1200, 1'b0);
        runTest("preClr", 0, 0);
        addPacket(2, 20, 16'd0, 1'b1);
        applyStimulus();
        repeat (5) stepCycle();
        clear = 1'b1;
        for (int c = 0; c < 4; c++) srcQ[c].delete();
        applyStimulus();
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("clrValid", 32'(outValid[0]), 0);
        checkOutput("clrLast", 32'(outLast[0]), 0);
        addPacket(2, 2, 16'h2200, 1'b0);
        addPacket(1, 2, 16'h1300, 1'b0);
        runTest("afterClr", 0, 0);

        // Randomised traffic on every instance with random output back-pressure.
        for (int r = 0; r < 6; r++) begin
            doReset();
            for (int c = 0; c < 4; c++) begin
                for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
                    addPacket(c, $urandom_range(1, 8), 16'd0, 1'b1);
                end
            end
            runTest($sformatf("rand%0d", r), r % 3, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
